// File: rtl/snake_rng_pkg.sv
// -----------------------------------------------------------------------------
// snake_rng_pkg
//   Shared definitions for the bounded random-number generator:
//     - lfsr_taps(width): maximal-length Galois (right-shift) tap masks for
//       register widths 8..32. Width 16 uses 16'hB400, the mask the
//       original game source used.
//     - rng_state_e: request FSM states.
// -----------------------------------------------------------------------------
package snake_rng_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } rng_state_e;

  // Tap mask for a right-shifting Galois LFSR: when the bit shifted out is 1,
  // the shifted value is XORed with this mask. Bit (width-1) is always set so
  // the feedback re-enters at the top of the register. Unsupported widths
  // return 0; the top level rejects such widths at elaboration.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_B400;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/rng_range_gen_lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
//   Free-running Galois LFSR, one step per clock, with a synchronous seed
//   load that takes priority over stepping. A zero load value is replaced
//   by SEED, so the lock-up state (all zeros) can never be entered.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (state returns to SEED)
//   load      in   load load_val on this edge instead of stepping
//   load_val  in   [LFSR_W-1:0] value to load (0 means "use SEED")
//   state     out  [LFSR_W-1:0] current register contents
// -----------------------------------------------------------------------------
module lfsr_core
  import snake_rng_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] step_val;

  // Right shift; feed the outgoing bit back through the tap mask.
  assign step_val = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAP_MASK : '0);

  always_comb begin
    lfsr_d = step_val;
    if (load) begin
      lfsr_d = (load_val == '0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/rng_range_gen.sv
// -----------------------------------------------------------------------------
// rng_range_gen
//   On-demand bounded random source. A request taken in IDLE moves to
//   SAMPLE, where each clock inspects the low OUT_W bits of the LFSR as a
//   candidate. A candidate below RANGE_MAX is returned. After MAX_TRIES
//   rejections, the last candidate is folded into range by subtracting
//   RANGE_MAX, so the answer always arrives within MAX_TRIES clocks.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   seed_load  in   load seed_in into the LFSR on this edge; aborts a request
//   seed_in    in   [LFSR_W-1:0] seed (0 substitutes SEED)
//   req        in   request one value; only looked at in IDLE
//   busy       out  request in progress
//   valid      out  one-cycle pulse, rand_num just updated
//   rand_num   out  [OUT_W-1:0] last accepted value, held between requests
//   rand_raw   out  [LFSR_W-1:0] current LFSR state
// -----------------------------------------------------------------------------
module rng_range_gen
  import snake_rng_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter int                OUT_W     = 9,
  parameter int                RANGE_MAX = 300,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  rand_num,
  output logic [LFSR_W-1:0] rand_raw
);

  // ---------------------------------------------------------------------------
  // Parameter sanity. The lower bound on RANGE_MAX is what makes the fallback
  // subtraction land inside [0, RANGE_MAX): any candidate is < 2^OUT_W and
  // 2^OUT_W - RANGE_MAX < RANGE_MAX.
  // ---------------------------------------------------------------------------
  generate
    if (LFSR_W < 8 || LFSR_W > 32) begin : g_bad_lfsr_w
      $error("rng_range_gen: LFSR_W must be in 8..32");
    end
    if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
      $error("rng_range_gen: OUT_W must be in 1..LFSR_W");
    end
    if (!((64'd1 << (OUT_W - 1)) < 64'(RANGE_MAX) &&
          64'(RANGE_MAX) <= (64'd1 << OUT_W))) begin : g_bad_range
      $error("rng_range_gen: need 2^(OUT_W-1) < RANGE_MAX <= 2^OUT_W");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("rng_range_gen: SEED must be nonzero");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
      $error("rng_range_gen: MAX_TRIES must be at least 1");
    end
  endgenerate

  // Try counter only has to reach MAX_TRIES-1.
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  // Compare/subtract are done one bit wider than the output so RANGE_MAX
  // equal to 2^OUT_W is representable.
  localparam logic [OUT_W:0] RANGE_EXT = (OUT_W + 1)'(RANGE_MAX);

  // ---------------------------------------------------------------------------
  // LFSR
  // ---------------------------------------------------------------------------
  logic [LFSR_W-1:0] lfsr_state;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr_state)
  );

  // ---------------------------------------------------------------------------
  // Candidate evaluation (uses the LFSR value present before this edge)
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]   cand_ext;
  logic             cand_ok;
  logic [OUT_W-1:0] cand_folded;

  assign cand_ext    = {1'b0, lfsr_state[OUT_W-1:0]};
  assign cand_ok     = (cand_ext < RANGE_EXT);
  assign cand_folded = OUT_W'(cand_ext - RANGE_EXT);

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  rng_state_e       state_q,    state_d;
  logic [TRY_W-1:0] tries_q,    tries_d;
  logic [OUT_W-1:0] rand_num_q, rand_num_d;
  logic             valid_q,    valid_d;

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    rand_num_d = rand_num_q;
    valid_d    = 1'b0;

    if (seed_load) begin
      // Reseeding abandons any request in flight and swallows a coincident
      // req: the candidate stream it was drawing from no longer exists.
      state_d = IDLE;
      tries_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = SAMPLE;
            tries_d = '0;
          end
        end
        SAMPLE: begin
          if (cand_ok) begin
            rand_num_d = lfsr_state[OUT_W-1:0];
            valid_d    = 1'b1;
            state_d    = IDLE;
            tries_d    = '0;
          end else if (tries_q != LAST_TRY) begin
            tries_d = tries_q + 1'b1;
          end else begin
            // Out of attempts: fold the rejected candidate into range.
            rand_num_d = cand_folded;
            valid_d    = 1'b1;
            state_d    = IDLE;
            tries_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          tries_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      rand_num_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      rand_num_q <= rand_num_d;
      valid_q    <= valid_d;
    end
  end

  assign busy     = (state_q == SAMPLE);
  assign valid    = valid_q;
  assign rand_num = rand_num_q;
  assign rand_raw = lfsr_state;

endmodule

// File: tb/tb_rng_range_gen.sv
// -----------------------------------------------------------------------------
// tb_rng_range_gen
//   Directed bench: a per-cycle vector table for the main DUT (default
//   parameters), hand-written sequences for abort / ignored req / reset
//   mid-request, and a second instance with MAX_TRIES=1 for the fallback.
// -----------------------------------------------------------------------------
module tb_rng_range_gen;

  logic        clk;
  logic        rst_n;

  // Main DUT (defaults)
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic        busy;
  logic        valid;
  logic [8:0]  rand_num;
  logic [15:0] rand_raw;

  // Fallback DUT (MAX_TRIES = 1)
  logic        f_seed_load;
  logic [15:0] f_seed_in;
  logic        f_req;
  logic        f_busy;
  logic        f_valid;
  logic [8:0]  f_rand_num;
  logic [15:0] f_rand_raw;

  int n_vec;
  int n_bad;

  rng_range_gen u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req       (req),
    .busy      (busy),
    .valid     (valid),
    .rand_num  (rand_num),
    .rand_raw  (rand_raw)
  );

  rng_range_gen #(
    .MAX_TRIES (1)
  ) u_dut_fb (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (f_seed_load),
    .seed_in   (f_seed_in),
    .req       (f_req),
    .busy      (f_busy),
    .valid     (f_valid),
    .rand_num  (f_rand_num),
    .rand_raw  (f_rand_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sl;
    logic [15:0] si;
    logic        rq;
    logic        eb;
    logic        ev;
    logic [8:0]  en;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; returns at posedge+1 with outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    seed_load = 1'b0; seed_in = 16'h0; req = 1'b0;
    f_seed_load = 1'b0; f_seed_in = 16'h0; f_req = 1'b0;

    //            sl    si        rq    busy  valid rand    raw
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0,   16'hE270};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0,   16'h7138};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0,   16'h389C};
    // zero seed -> SEED substituted, then request returns 112
    vecs[3]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0,   16'hACE1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9'd0,   16'hE270};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd112, 16'h7138};
    // req during the valid cycle starts a new request, candidate 0x09C=156
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9'd112, 16'h389C};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd156, 16'h1C4E};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd156, 16'h0E27};
    // single rejection: 511 rejected, then 255 accepted
    vecs[9]  = '{1'b1, 16'h03FE, 1'b0, 1'b0, 1'b0, 9'd156, 16'h03FE};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9'd156, 16'h01FF};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 9'd156, 16'hB4FF};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 9'd255, 16'hEE7F};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd255, 16'hC33F};
    // seed_load and req on the same IDLE edge: req dropped
    vecs[14] = '{1'b1, 16'h03FE, 1'b1, 1'b0, 1'b0, 9'd255, 16'h03FE};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd255, 16'h01FF};

    // Reset state
    #12;
    chk("reset_raw",   32'(rand_raw), 32'h0000_ACE1);
    chk("reset_busy",  32'(busy),     32'd0);
    chk("reset_valid", 32'(valid),    32'd0);
    chk("reset_rand",  32'(rand_num), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      seed_load = vecs[i].sl;
      seed_in   = vecs[i].si;
      req       = vecs[i].rq;
      tick();
      $display("vec %0d: sl=%0d si=%h req=%0d -> busy=%0d valid=%0d rand=%0d raw=%h",
               i, vecs[i].sl, vecs[i].si, vecs[i].rq, busy, valid, rand_num, rand_raw);
      chk($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].eb));
      chk($sformatf("vec%0d_valid", i), 32'(valid),    32'(vecs[i].ev));
      chk($sformatf("vec%0d_rand", i),  32'(rand_num), 32'(vecs[i].en));
      chk($sformatf("vec%0d_raw", i),   32'(rand_raw), 32'(vecs[i].er));
    end
    seed_load = 1'b0; seed_in = 16'h0; req = 1'b0;

    // Abort: seed_load while busy -> IDLE, no valid, rand_num kept
    seed_load = 1'b1; seed_in = 16'h03FE; tick();
    seed_load = 1'b0; req = 1'b1; tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    req = 1'b0; seed_load = 1'b1; seed_in = 16'h1234; tick();
    seed_load = 1'b0; seed_in = 16'h0;
    $display("abort: busy=%0d valid=%0d rand=%0d", busy, valid, rand_num);
    chk("abort_busy",  32'(busy),     32'd0);
    chk("abort_valid", 32'(valid),    32'd0);
    chk("abort_rand",  32'(rand_num), 32'd255);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);

    // Second req during SAMPLE is ignored: exactly one valid pulse
    seed_load = 1'b1; seed_in = 16'h03FE; tick();
    seed_load = 1'b0; seed_in = 16'h0; req = 1'b1;
    pulses = 0;
    tick();                     // e1: request taken
    tick();                     // e2: 511 rejected, req ignored
    chk("ignore_busy_e2", 32'(busy), 32'd1);
    tick();                     // e3: 255 accepted
    if (valid) pulses++;
    req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid) pulses++;
    end
    $display("ignore: pulses=%0d rand=%0d", pulses, rand_num);
    chk("ignore_pulses", 32'(pulses),   32'd1);
    chk("ignore_rand",   32'(rand_num), 32'd255);

    // Fallback instance: MAX_TRIES=1, 511 rejected on the only try -> 211
    f_seed_load = 1'b1; f_seed_in = 16'h03FE; tick();
    f_seed_load = 1'b0; f_seed_in = 16'h0; f_req = 1'b1; tick();
    chk("fb_busy", 32'(f_busy), 32'd1);
    f_req = 1'b0; tick();
    $display("fallback: busy=%0d valid=%0d rand=%0d", f_busy, f_valid, f_rand_num);
    chk("fb_valid",     32'(f_valid),    32'd1);
    chk("fb_rand",      32'(f_rand_num), 32'd211);
    chk("fb_busy_done", 32'(f_busy),     32'd0);
    tick();
    chk("fb_valid_drop", 32'(f_valid), 32'd0);

    // Reset mid-request: asynchronous, between edges
    seed_load = 1'b1; seed_in = 16'h03FE; tick();
    seed_load = 1'b0; seed_in = 16'h0; req = 1'b1; tick();
    req = 1'b0; tick();         // 511 rejected, still busy
    chk("rst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-request: busy=%0d valid=%0d rand=%0d raw=%h",
             busy, valid, rand_num, rand_raw);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_valid", 32'(valid),    32'd0);
    chk("rst_rand",  32'(rand_num), 32'd0);
    chk("rst_raw",   32'(rand_raw), 32'h0000_ACE1);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (valid) pulses++;
    end
    chk("rst_no_pulse", 32'(pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
